// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the data-cache responder.
// Contents: FSM state encoding, default uncached-region base, word and
// byte-enable widths, and a byte-enable merge helper used by the line store.
package dcache_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  // Addresses at or above this value bypass the cache.
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_FILL  = 2'd1,
    DC_RESP  = 2'd2,
    DC_WRITE = 2'd3
  } dc_state_e;

  // Replace the bytes of old_word selected by be with the bytes of new_word.
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_word,
                                                 input logic [WORD_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] r;
    r = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped data cache: valid, tag and data arrays.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears valid bits)
//   rd_index              lookup index; rd_valid/rd_tag/rd_data are combinational
//   wr_en, wr_index       write strobe and target line
//   wr_be, wr_data        byte-enabled data write
//   wr_fill, wr_tag       when set, also writes the tag and marks the line valid
module dcache_array
  import dcache_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [BE_W-1:0]       wr_be,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  wr_fill,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [WORD_W-1:0]   data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are ignored until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= be_merge(data_q[wr_index], wr_data, wr_be);
      if (wr_fill) tag_q[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and memory port B. Generates the pipeline data stall. Addresses at or
// above MMIO_BASE always go to memory.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_read, req_write              MEM-stage load / store request
//   req_addr, req_wdata, req_be      request byte address, store data, byte enables
//   rdata                            load result (valid when req_read && !stall)
//   stall                            pipeline-wide data stall
//   mem_addr, mem_wdata, mem_be      backing-memory address / write data / enables
//   mem_we                           one-cycle backing-memory write strobe
//   mem_rdata                        backing-memory read data (MEM_LATENCY cycles)
// Optional: define DCACHE_STATS_EN to add saturating hit_count / miss_count
// outputs counting completed cached loads.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic [WORD_W-1:0] rdata,
  output logic              stall,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int unsigned CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  dc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] resp_q, resp_d;
  logic [WORD_W-1:0] rdata_q;
  logic [31:0]       mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0] req_index, fill_index, arr_index;
  logic [TAG_BITS-1:0]   req_tag, fill_tag, arr_tag;
  logic                  req_uncached, fill_uncached, hit;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [WORD_W-1:0]     rd_data, arr_wdata;
  logic [BE_W-1:0]       arr_be;
  logic                  arr_we, arr_fill;

  assign req_index    = req_addr[INDEX_BITS+1:2];
  assign req_tag      = req_addr[31:INDEX_BITS+2];
  assign req_uncached = (req_addr >= MMIO_BASE);

  // The fill completes from the latched address so a dropped request still
  // lands in the right line.
  assign fill_index    = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag      = mem_addr_q[31:INDEX_BITS+2];
  assign fill_uncached = (mem_addr_q >= MMIO_BASE);

  assign hit = rd_valid && (rd_tag == req_tag) && !req_uncached;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_index (arr_index),
    .wr_be    (arr_be),
    .wr_data  (arr_wdata),
    .wr_fill  (arr_fill),
    .wr_tag   (arr_tag)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    rdata     = rdata_q;
    arr_we    = 1'b0;
    arr_fill  = 1'b0;
    arr_index = req_index;
    arr_tag   = req_tag;
    arr_be    = req_be;
    arr_wdata = req_wdata;

    unique case (state_q)
      DC_IDLE: begin
        if (req_read) begin
          if (hit) begin
            rdata = rd_data;
          end else begin
            stall    = 1'b1;
            mem_addr = {req_addr[31:2], 2'b00};
            cnt_d    = CNT_W'(MEM_LATENCY - 1);
            state_d  = DC_FILL;
          end
        end else if (req_write) begin
          stall   = 1'b1;
          state_d = DC_WRITE;
        end
      end
      DC_FILL: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          resp_d  = mem_rdata;
          state_d = DC_RESP;
          if (!fill_uncached) begin
            arr_we    = 1'b1;
            arr_fill  = 1'b1;
            arr_index = fill_index;
            arr_tag   = fill_tag;
            arr_be    = '1;
            arr_wdata = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DC_RESP: begin
        rdata   = resp_q;
        state_d = DC_IDLE;
      end
      DC_WRITE: begin
        mem_we    = 1'b1;
        mem_be    = req_be;
        mem_addr  = {req_addr[31:2], 2'b00};
        mem_wdata = req_wdata;
        // Write-through; only update the line if it is already present.
        arr_we    = hit;
        state_d   = DC_IDLE;
      end
      default: state_d = DC_IDLE;
    endcase

    // Outputs drop to their reset values the moment reset is asserted.
    if (rst) begin
      stall     = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      rdata     = '0;
      arr_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DC_IDLE;
      cnt_q       <= '0;
      resp_q      <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic stat_hit, stat_miss;

  assign stat_hit  = (state_q == DC_IDLE) && req_read && hit;
  assign stat_miss = (state_q == DC_FILL) && (cnt_q == '0) && !fill_uncached;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (stat_hit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (stat_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: transaction-level cache/memory
// model, per-cycle compare process, directed scenarios plus random traffic.
module tb_dcache_responder;

  localparam int unsigned LAT  = 2;
  localparam logic [31:0] MMIO = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        stall, mem_we;
  logic [3:0]  mem_be;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_responder #(
    .INDEX_BITS  (6),
    .MEM_LATENCY (LAT),
    .MMIO_BASE   (MMIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rdata     (rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return {i[15:0] ^ 16'hA5C3, 16'h1000 + i[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Backing memory seen by the DUT (4 KiB window plus a counting MMIO register).
  logic [31:0] bmem [0:1023];
  logic        mem_init;
  logic [31:0] mmio_val;

  assign mem_rdata = (mem_addr >= MMIO) ? mmio_val : bmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) bmem[i] <= init_word(i);
    end else if (mem_we && (mem_addr < 32'h1000)) begin
      bmem[mem_addr[11:2]] <= merge(bmem[mem_addr[11:2]], mem_wdata, mem_be);
    end
  end

  // Reference model: architectural cache contents and memory image.
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_rdata;
  int unsigned m_hits, m_misses;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations published by the driver, checked on the falling edge.
  logic        chk_en;
  logic        exp_stall, exp_we, exp_chk_addr, exp_chk_wr, exp_chk_rdata;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      if (exp_chk_addr) check("mem_addr", mem_addr, exp_addr);
      if (exp_chk_wr) begin
        check("mem_wdata", mem_wdata, exp_wdata);
        check("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
      end
      if (exp_chk_rdata) check("rdata", rdata, exp_rdata);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    last_rdata = '0;
    m_hits     = 0;
    m_misses   = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle();
    req_read = 1'b0; req_write = 1'b0;
    exp_stall = 1'b0; exp_we = 1'b0; exp_chk_addr = 1'b0; exp_chk_wr = 1'b0;
    exp_chk_rdata = 1'b1; exp_rdata = last_rdata;
    next_cycle();
  endtask

  task automatic do_load(input logic [31:0] a, output int ns, output logic [31:0] got);
    logic [5:0]  idx;
    logic [23:0] tg;
    logic        unc, hit;
    logic [31:0] dat;
    int          n;
    idx = a[7:2];
    tg  = a[31:8];
    unc = (a >= MMIO);
    hit = !unc && m_valid[idx] && (m_tag[idx] == tg);
    dat = hit ? m_data[idx] : (unc ? mmio_val : ref_mem[a[11:2]]);
    n   = hit ? 0 : int'(LAT) + 1;
    req_read = 1'b1; req_write = 1'b0; req_addr = a;
    req_wdata = $urandom; req_be = 4'($urandom);
    ns  = 0;
    got = '0;
    for (int i = 0; i <= n; i++) begin
      exp_stall = (i < n); exp_we = 1'b0; exp_chk_wr = 1'b0;
      exp_chk_addr = (i < n); exp_addr = {a[31:2], 2'b00};
      exp_chk_rdata = (i == n); exp_rdata = dat;
      @(negedge clk);
      if (stall) ns++;
      if (i == n) got = rdata;
      next_cycle();
    end
    last_rdata = dat;
    if (hit) m_hits++;
    else if (!unc) begin
      m_misses++;
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = dat;
    end
    if (unc) mmio_val = mmio_val + 32'd1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int ns, output logic we_seen);
    logic [5:0] idx;
    logic       hit;
    idx = a[7:2];
    hit = (a < MMIO) && m_valid[idx] && (m_tag[idx] == a[31:8]);
    req_read = 1'b0; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    exp_stall = 1'b1; exp_we = 1'b0; exp_chk_addr = 1'b0; exp_chk_wr = 1'b0;
    exp_chk_rdata = 1'b0;
    @(negedge clk);
    ns = stall ? 1 : 0;
    next_cycle();
    exp_stall = 1'b0; exp_we = 1'b1; exp_chk_addr = 1'b1; exp_addr = {a[31:2], 2'b00};
    exp_chk_wr = 1'b1; exp_wdata = d; exp_be = be;
    @(negedge clk);
    if (stall) ns++;
    we_seen = mem_we;
    next_cycle();
    if (a < 32'h1000) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, be);
    if (hit) m_data[idx] = merge(m_data[idx], d, be);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  int          ns;
  logic [31:0] got;
  logic        we_seen;
  logic [31:0] ra;

  initial begin
    chk_en = 1'b0; rst = 1'b0; mem_init = 1'b1; mmio_val = 32'd1;
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    exp_stall = 1'b0; exp_we = 1'b0; exp_chk_addr = 1'b0; exp_chk_wr = 1'b0;
    exp_chk_rdata = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_be = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 mem_init = 1'b0;
    check_quiet("reset");
    @(negedge clk) rst = 1'b0;
    next_cycle();
    chk_en = 1'b1;

    // Cold miss then same-cycle hit.
    do_load(32'h0000_0040, ns, got);
    check("cold_stalls", ns, 32'd3);
    check("cold_data", got, 32'hDEADBEEF);
    do_load(32'h0000_0040, ns, got);
    check("hit_stalls", ns, 32'd0);
    check("hit_data", got, 32'hDEADBEEF);
    do_idle();

    // Store hit merges one byte.
    do_store(32'h0000_0040, 32'h0000_00AA, 4'b0001, ns, we_seen);
    check("store_stalls", ns, 32'd1);
    check("store_we", {31'b0, we_seen}, 32'd1);
    do_load(32'h0000_0040, ns, got);
    check("merge_stalls", ns, 32'd0);
    check("merge_data", got, 32'hDEADBEAA);

    // Conflict eviction.
    do_load(32'h0000_0140, ns, got);
    check("conflict_stalls", ns, 32'd3);
    do_load(32'h0000_0040, ns, got);
    check("evicted_stalls", ns, 32'd3);
    check("evicted_data", got, 32'hDEADBEAA);

    // Uncached reads never hit.
    do_load(32'hFFFF_FC00, ns, got);
    check("mmio1_stalls", ns, 32'd3);
    check("mmio1_data", got, 32'd1);
    do_load(32'hFFFF_FC00, ns, got);
    check("mmio2_stalls", ns, 32'd3);
    check("mmio2_data", got, 32'd2);
    do_idle();

    // Store miss does not allocate.
    do_store(32'h0000_0080, 32'h1234_5678, 4'b1111, ns, we_seen);
    check("smiss_we", {31'b0, we_seen}, 32'd1);
    do_load(32'h0000_0080, ns, got);
    check("smiss_load_stalls", ns, 32'd3);
    check("smiss_load_data", got, 32'h1234_5678);

    // Reset while filling.
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h0000_00C0;
    exp_stall = 1'b1; exp_we = 1'b0; exp_chk_addr = 1'b1; exp_addr = 32'h0000_00C0;
    exp_chk_wr = 1'b0; exp_chk_rdata = 1'b0;
    next_cycle();
    chk_en = 1'b0;
    check("fill_stall", {31'b0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1 check_quiet("midreset");
    @(negedge clk);
    check("midreset_hold_stall", {31'b0, stall}, 32'd0);
    req_read = 1'b0;
    next_cycle();
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    do_load(32'h0000_00C0, ns, got);
    check("postrst_stalls", ns, 32'd3);
    do_load(32'h0000_0040, ns, got);
    check("postrst_valid_cleared", ns, 32'd3);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0:       ra = MMIO | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
        1:       ra = 32'($urandom_range(0, 32'hFFF));
        default: ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                      | 32'($urandom_range(0, 3));
      endcase
      if (op < 45) do_load(ra, ns, got);
      else if (op < 75) do_store(ra, $urandom, 4'($urandom), ns, we_seen);
      else do_idle();
    end
    do_idle();

`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the MEM stage and data port B of the unified memory.
- Acts as responder to the MEM-stage load/store initiator and generates the pipeline-wide data stall (DStall).
- MMIO addresses bypass the cache and always go to memory, so peripheral reads are never stale.

Parameters:
- INDEX_BITS, 6, line-index width; 2^INDEX_BITS one-word lines.
- MEM_LATENCY, 2, cycles from mem_addr issue to valid mem_rdata (>=1).
- MMIO_BASE, 32'hFFFF_FC00, addresses >= this are uncached.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_read  in  1  MEM-stage load request; held stable while stall=1.
- req_write  in  1  MEM-stage store request; req_read and req_write are never both 1.
- req_addr  in  32  byte address; [1:0] ignored for array indexing.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  store byte enables.
- rdata  out  32  load result word; valid when req_read=1 and stall=0.
- stall  out  1  DStall to PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- mem_addr  out  32  word-aligned backing-memory address.
- mem_wdata  out  32  backing-memory write data.
- mem_be  out  4  backing-memory byte enables.
- mem_we  out  1  backing-memory write strobe, one cycle.
- mem_rdata  in  32  backing-memory read data.

Behaviour:
- Address split:
  - index = req_addr[INDEX_BITS+1:2]
  - tag = req_addr[31:INDEX_BITS+2]
  - uncached = (req_addr >= MMIO_BASE)
- Arrays: valid[], tag[], data[]. Read combinationally; written on clk.
- Reset (async):
  - state=IDLE, all valid bits 0, latency counter 0.
  - stall=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0.
  - A request in flight is dropped; no partial line is validated.
- hit = valid[index] && tag match && !uncached.
- States: IDLE, FILL, RESP, WRITE.
- IDLE:
  - Read hit: stall=0, rdata=data[index] in the same cycle (0-cycle latency).
  - Read miss or uncached read: stall=1 combinationally; mem_addr={req_addr[31:2],2'b00}; counter loaded with MEM_LATENCY-1; go to FILL.
  - Write (any): stall=1; go to WRITE.
  - No request: stall=0, rdata holds its last value.
- FILL:
  - stall=1; mem_addr held; counter decrements.
  - At counter==0: capture mem_rdata into the response register.
  - If not uncached, also write the line (data, tag, valid=1).
  - Go to RESP.
- RESP: stall=0; rdata=response register; return to IDLE next cycle. Miss latency is MEM_LATENCY+1 stall cycles.
- WRITE:
  - stall=0; mem_we=1; mem_addr/mem_wdata/mem_be driven from the request.
  - If the line hits, merge req_wdata into data[index] per req_be. Valid and tag are unchanged.
  - On a miss, no allocate.
  - Return to IDLE. A store costs exactly 1 stall cycle.
- mem_we is 1 only in WRITE.
- Back-to-back store then load to the same address: the load sees the merged value (hit) or fetches from memory after the write has committed (miss).
- A request deasserted while stall=1 is a protocol violation; the FSM completes the transaction anyway.
- Address wrap: index/tag fields are pure bit slices, no arithmetic.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both cleared by rst.
  - Increments once per completed cached load: hit in IDLE, miss on FILL→RESP.
  - Counters saturate at 32'hFFFF_FFFF. Stores and uncached accesses are not counted.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared constants package: state encodings (DC_IDLE, DC_FILL, DC_RESP, DC_WRITE), MMIO_BASE default, word/BE widths.
- One natural sub-module, dcache_array: valid/tag/data storage with combinational read and byte-enable write port.
- FSM, latency counter and bypass logic stay in the top.

Test Plan:
- Cold read 0x0000_0040, mem_rdata=32'hDEADBEEF, MEM_LATENCY=2 → stall high 3 cycles; rdata=DEADBEEF in RESP. Repeat read → stall=0, same-cycle hit.
- Store 0x0000_0040, wdata=32'h000000AA, be=4'b0001, after it is cached → 1 stall cycle; mem_we pulse with be=0001. Next load returns 32'hDEADBEAA with no stall.
- Conflict: load 0x0000_0040, then load 0x0000_0140 (same index, different tag) → second misses and refills. Reload of 0x40 misses again.
- Uncached read 0xFFFF_FC00 twice, mem_rdata 0x1 then 0x2 → both miss; rdata 0x1 then 0x2; valid never set.
- Store miss to 0x0000_0080 → mem_we pulse. A following load of 0x80 misses (no allocate).
- Assert rst during FILL → stall=0, mem_we=0 immediately. A subsequent load of the same address misses.
